// File: rtl/riscv_exec_pipe.sv
// Two-stage RV32I integer execute pipe: S1 holds the instruction and reads operands,
// S2 holds the retired result. The register write happens on the edge that loads S2.
module riscv_exec_pipe #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] rd,
  output logic             illegal,
  output logic [31:0]      retired_cnt
);
  // Handshake: a side transfers on the edge where its valid and ready are both 1;
  // valid never depends on ready, and a held stage keeps every field unchanged.
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic             s1_valid;
  logic [31:0]      s1_instr;
  logic [WIDTH-1:0] regs [NREGS];
  logic             s1_adv;

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [4:0]       rs1_idx, rs2_idx, rd_idx;
  logic [WIDTH-1:0] rs1_val, rs2_val, imm, lui_val, op_b, result;
  logic [SW-1:0]    shamt;
  logic             is_op, legal, use_rs1, use_rs2, use_rd, shift_hi_ok;

  assign s1_adv      = s1_valid && (!out_valid || out_ready);
  assign instr_ready = !rst && (!s1_valid || s1_adv);

  assign opcode  = s1_instr[6:0];
  assign f3      = s1_instr[14:12];
  assign f7      = s1_instr[31:25];
  assign rs1_idx = s1_instr[19:15];
  assign rs2_idx = s1_instr[24:20];
  assign rd_idx  = s1_instr[11:7];
  assign is_op   = (opcode == OPC_OP);
  assign imm     = WIDTH'($signed(s1_instr[31:20]));
  assign lui_val = WIDTH'($signed({s1_instr[31:12], 12'b0}));
  assign op_b    = is_op ? rs2_val : imm;
  assign shamt   = op_b[SW-1:0];
  // Immediate shifts: bit 30 selects SRAI; bit 25 is part of shamt only on 64-bit.
  assign shift_hi_ok = !s1_instr[31] && (s1_instr[29:26] == 4'b0) &&
                       ((WIDTH == 64) || !s1_instr[25]);

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != 5'd0 && {1'b0, rs1_idx} < NREGS_W) rs1_val = regs[rs1_idx[AW-1:0]];
    if (rs2_idx != 5'd0 && {1'b0, rs2_idx} < NREGS_W) rs2_val = regs[rs2_idx[AW-1:0]];
  end

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        legal   = (f7 == 7'b0000000) ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        if (f3 == 3'b001)      legal = shift_hi_ok && !s1_instr[30];
        else if (f3 == 3'b101) legal = shift_hi_ok;
        else                   legal = 1'b1;
      end
      OPC_LUI: begin
        use_rd = 1'b1;
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if ((use_rs1 && {1'b0, rs1_idx} >= NREGS_W) ||
        (use_rs2 && {1'b0, rs2_idx} >= NREGS_W) ||
        (use_rd  && {1'b0, rd_idx}  >= NREGS_W))
      legal = 1'b0;
  end

  always_comb begin
    result = '0;
    if (opcode == OPC_LUI) begin
      result = lui_val;
    end else begin
      case (f3)
        3'b000: result = (is_op && s1_instr[30]) ? rs1_val - op_b : rs1_val + op_b;
        3'b001: result = rs1_val << shamt;
        3'b010: result = WIDTH'($signed(rs1_val) < $signed(op_b));
        3'b011: result = WIDTH'(rs1_val < op_b);
        3'b100: result = rs1_val ^ op_b;
        3'b101: result = s1_instr[30] ? WIDTH'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
        3'b110: result = rs1_val | op_b;
        default: result = rs1_val & op_b;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_instr    <= '0;
      out_valid   <= 1'b0;
      rd          <= '0;
      rd_addr     <= '0;
      illegal     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (instr_ready) begin
        s1_valid <= instr_valid;
        if (instr_valid) s1_instr <= instr;
      end
      if (s1_adv) begin
        out_valid <= 1'b1;
        illegal   <= !legal;
        rd        <= legal ? result : '0;
        rd_addr   <= legal ? rd_idx : 5'd0;
        if (legal) retired_cnt <= retired_cnt + 32'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Written on the S2-load edge so the next S1 occupant reads the fresh value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (s1_adv && legal && rd_idx != 5'd0) begin
      regs[rd_idx[AW-1:0]] <= result;
    end
  end
endmodule

// File: tb/tb_riscv_exec_pipe.sv
// Directed bench for riscv_exec_pipe: a 32-register instance (a_*) and a 16-register
// instance (b_*) sharing clock and reset; expectations are hand-computed constants.
module tb_riscv_exec_pipe;
  logic        clk;
  logic        rst;
  logic        out_ready;

  logic        a_instr_valid, a_instr_ready, a_out_valid, a_illegal;
  logic [31:0] a_instr, a_rd, a_retired_cnt;
  logic [4:0]  a_rd_addr;

  logic        b_instr_valid, b_instr_ready, b_out_valid, b_illegal;
  logic [31:0] b_instr, b_rd, b_retired_cnt;
  logic [4:0]  b_rd_addr;

  int vectors;
  int miscompares;
  int exp_cnt;

  riscv_exec_pipe #(.WIDTH(32), .NREGS(32)) dut_a (
    .clk(clk), .rst(rst),
    .instr_valid(a_instr_valid), .instr_ready(a_instr_ready), .instr(a_instr),
    .out_ready(out_ready), .out_valid(a_out_valid), .rd_addr(a_rd_addr),
    .rd(a_rd), .illegal(a_illegal), .retired_cnt(a_retired_cnt)
  );

  riscv_exec_pipe #(.WIDTH(32), .NREGS(16)) dut_b (
    .clk(clk), .rst(rst),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .instr(b_instr),
    .out_ready(out_ready), .out_valid(b_out_valid), .rd_addr(b_rd_addr),
    .rd(b_rd), .illegal(b_illegal), .retired_cnt(b_retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string tag, input logic [4:0] addr,
                          input logic [31:0] val, input logic ill);
    check({tag, ".out_valid"}, a_out_valid, 1'b1);
    check({tag, ".rd_addr"}, a_rd_addr, addr);
    check({tag, ".rd"}, a_rd, val);
    check({tag, ".illegal"}, a_illegal, ill);
    check({tag, ".retired_cnt"}, a_retired_cnt, exp_cnt);
  endtask

  // Issue one instruction to instance A, then check its result two edges later.
  task automatic run_a(input string tag, input logic [31:0] ins, input logic [4:0] addr,
                       input logic [31:0] val, input logic ill);
    a_instr_valid = 1'b1;
    a_instr       = ins;
    tick();
    a_instr_valid = 1'b0;
    tick();
    if (!ill) exp_cnt++;
    expect_a(tag, addr, val, ill);
  endtask

  task automatic run_b(input string tag, input logic [31:0] ins, input logic [4:0] addr,
                       input logic [31:0] val, input logic ill, input int cnt);
    b_instr_valid = 1'b1;
    b_instr       = ins;
    tick();
    b_instr_valid = 1'b0;
    tick();
    check({tag, ".out_valid"}, b_out_valid, 1'b1);
    check({tag, ".rd_addr"}, b_rd_addr, addr);
    check({tag, ".rd"}, b_rd, val);
    check({tag, ".illegal"}, b_illegal, ill);
    check({tag, ".retired_cnt"}, b_retired_cnt, cnt);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_cnt       = 0;
    rst           = 1'b1;
    out_ready     = 1'b1;
    a_instr_valid = 1'b0;
    a_instr       = '0;
    b_instr_valid = 1'b0;
    b_instr       = '0;

    // Reset state
    tick();
    tick();
    check("rst.instr_ready", a_instr_ready, 1'b0);
    check("rst.out_valid", a_out_valid, 1'b0);
    check("rst.rd", a_rd, 32'd0);
    check("rst.rd_addr", a_rd_addr, 5'd0);
    check("rst.retired_cnt", a_retired_cnt, 32'd0);
    rst = 1'b0;
    #1;
    check("rel.instr_ready", a_instr_ready, 1'b1);

    // Latency: nothing visible after the acceptance edge, result after the second
    a_instr_valid = 1'b1;
    a_instr       = 32'h0050_0093;
    tick();
    a_instr_valid = 1'b0;
    check("addi.lat1", a_out_valid, 1'b0);
    tick();
    exp_cnt = 1;
    expect_a("addi_x1_5", 5'd1, 32'd5, 1'b0);

    // Set x1=3 so the next pair depends on the same-edge write of x1=5
    run_a("addi_x1_3", 32'h0030_0093, 5'd1, 32'd3, 1'b0);

    // Back-to-back, no bubble
    a_instr_valid = 1'b1;
    a_instr       = 32'h0050_0093;
    tick();
    a_instr = 32'h0010_8133;
    tick();
    exp_cnt++;
    expect_a("b2b.first", 5'd1, 32'd5, 1'b0);
    a_instr_valid = 1'b0;
    tick();
    exp_cnt++;
    expect_a("b2b.second", 5'd2, 32'd10, 1'b0);

    run_a("addi_x3_m8", 32'hFF80_0193, 5'd3, 32'hFFFF_FFF8, 1'b0);
    run_a("srai_x4", 32'h4011_D213, 5'd4, 32'hFFFF_FFFC, 1'b0);
    run_a("addi_x0_7", 32'h0070_0013, 5'd0, 32'd7, 1'b0);
    run_a("add_x5_x0", 32'h0000_02B3, 5'd5, 32'd0, 1'b0);
    run_a("sub_x6", 32'h4032_0333, 5'd6, 32'd4, 1'b0);
    run_a("slt_x7", 32'h0011_A3B3, 5'd7, 32'd1, 1'b0);
    run_a("sltu_x7", 32'h0011_B3B3, 5'd7, 32'd0, 1'b0);
    run_a("lui_x8", 32'h8000_0437, 5'd8, 32'h8000_0000, 1'b0);
    run_a("srli_x12", 32'h01C1_D613, 5'd12, 32'h0000_000F, 1'b0);
    run_a("ill_opc", 32'h0000_007F, 5'd0, 32'd0, 1'b1);
    run_a("ill_f7", 32'h0210_8133, 5'd0, 32'd0, 1'b1);

    // Backpressure: two instructions held while out_ready=0
    a_instr_valid = 1'b1;
    a_instr       = 32'h0010_0493;
    tick();
    out_ready = 1'b0;
    a_instr   = 32'h0020_0513;
    #1;
    check("bp.ready_s1", a_instr_ready, 1'b1);
    tick();
    a_instr_valid = 1'b0;
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      check("bp.instr_ready", a_instr_ready, 1'b0);
      expect_a("bp.hold", 5'd9, 32'd1, 1'b0);
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.ready_release", a_instr_ready, 1'b1);
    tick();
    exp_cnt++;
    expect_a("bp.second", 5'd10, 32'd2, 1'b0);
    tick();
    check("bp.drained", a_out_valid, 1'b0);

    // Reset mid-stream discards in-flight work immediately
    a_instr_valid = 1'b1;
    a_instr       = 32'h0030_0593;
    tick();
    out_ready = 1'b0;
    a_instr   = 32'h0040_0613;
    tick();
    a_instr_valid = 1'b0;
    check("mid.out_valid_before", a_out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid.out_valid", a_out_valid, 1'b0);
    check("mid.rd", a_rd, 32'd0);
    check("mid.retired_cnt", a_retired_cnt, 32'd0);
    check("mid.instr_ready", a_instr_ready, 1'b0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = 0;
    run_a("post_rst_add", 32'h00B6_06B3, 5'd13, 32'd0, 1'b0);

    // 16-register instance: indices >= 16 are illegal
    run_b("b.addi_x20", 32'h0010_0A13, 5'd0, 32'd0, 1'b1, 0);
    run_b("b.rs1_x20", 32'h000A_0093, 5'd0, 32'd0, 1'b1, 0);
    run_b("b.addi_x5", 32'h0050_0293, 5'd5, 32'd5, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
